// File: rtl/pool_window_gen.sv
// ---------------------------------------------------------------------------
// pool_window_gen
//   Streaming 2x2 / stride-2 window extractor in front of the average-pooling
//   stage. Pixels arrive in raster order, map by map, IFM_DEPTH maps per
//   frame. A shift register of one row plus one pixel provides the three
//   older window pixels when the pixel completing a window arrives; the
//   window is then presented for one cycle with its pooled-map address.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   asynchronous, active-high
//   clear           in   synchronous restart of counters and outputs
//   pixel_valid     in   pixel_in is accepted on this edge
//   pixel_in        in   IFM pixel (opaque DATA_WIDTH bits)
//   pool_enable     out  one-cycle strobe: window outputs valid
//   pool_data_out_1 out  window pixel (r-1,c-1)
//   pool_data_out_2 out  window pixel (r-1,c)
//   pool_data_out_3 out  window pixel (r,c-1)
//   pool_data_out_4 out  window pixel (r,c)
//   pool_addr       out  row-major address of the window in the pooled map
//   map_idx         out  map the window belongs to
//   map_done        out  pulse with the last accepted pixel of a map
//   frame_done      out  pulse with the last accepted pixel of the last map
// ---------------------------------------------------------------------------
module pool_window_gen #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 3,
    parameter int IFM_SIZE_NEXT         = (IFM_SIZE - 2) / 2 + 1,
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int BUF_SIZE              = IFM_SIZE + 1,
    localparam int MAP_W                = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             pixel_valid,
    input  logic [DATA_WIDTH-1:0]            pixel_in,
    output logic                             pool_enable,
    output logic [DATA_WIDTH-1:0]            pool_data_out_1,
    output logic [DATA_WIDTH-1:0]            pool_data_out_2,
    output logic [DATA_WIDTH-1:0]            pool_data_out_3,
    output logic [DATA_WIDTH-1:0]            pool_data_out_4,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] pool_addr,
    output logic [MAP_W-1:0]                 map_idx,
    output logic                             map_done,
    output logic                             frame_done
);

    localparam int RC_W = $clog2(IFM_SIZE);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(IFM_SIZE - 1);
    // Highest row/column index that can still close a window; for odd
    // IFM_SIZE the final row and column are excluded.
    localparam logic [RC_W-1:0]  WIN_LAST = RC_W'(2 * IFM_SIZE_NEXT - 1);
    localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(IFM_DEPTH - 1);

    logic [DATA_WIDTH-1:0]            sr [BUF_SIZE];
    logic [RC_W-1:0]                  col;
    logic [RC_W-1:0]                  row;
    logic [MAP_W-1:0]                 map_cnt;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] win_cnt;

    logic accept;
    logic at_col_end;
    logic at_row_end;
    logic at_map_last;
    logic win_hit;

    assign accept      = pixel_valid && !clear;
    assign at_col_end  = (col == RC_LAST);
    assign at_row_end  = (row == RC_LAST);
    assign at_map_last = (map_cnt == MAP_LAST);
    assign win_hit     = row[0] && col[0] && (row <= WIN_LAST) && (col <= WIN_LAST);

    // Line buffer: data only, so no reset. Stale contents after a reset or
    // map change are never read because a window needs row >= 1 and col >= 1
    // of the current map, by which point the taps hold current-map pixels.
    always_ff @(posedge clk) begin
        if (accept) begin
            sr[0] <= pixel_in;
            for (int k = 1; k < BUF_SIZE; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    // Stage boundary: accepted pixel -> registered window, address, strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col             <= '0;
            row             <= '0;
            map_cnt         <= '0;
            win_cnt         <= '0;
            pool_enable     <= 1'b0;
            pool_data_out_1 <= '0;
            pool_data_out_2 <= '0;
            pool_data_out_3 <= '0;
            pool_data_out_4 <= '0;
            pool_addr       <= '0;
            map_idx         <= '0;
            map_done        <= 1'b0;
            frame_done      <= 1'b0;
        end else if (clear) begin
            col             <= '0;
            row             <= '0;
            map_cnt         <= '0;
            win_cnt         <= '0;
            pool_enable     <= 1'b0;
            pool_data_out_1 <= '0;
            pool_data_out_2 <= '0;
            pool_data_out_3 <= '0;
            pool_data_out_4 <= '0;
            pool_addr       <= '0;
            map_idx         <= '0;
            map_done        <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            pool_enable <= 1'b0;
            map_done    <= 1'b0;
            frame_done  <= 1'b0;
            if (pixel_valid) begin
                if (win_hit) begin
                    pool_data_out_1 <= sr[IFM_SIZE];
                    pool_data_out_2 <= sr[IFM_SIZE-1];
                    pool_data_out_3 <= sr[0];
                    pool_data_out_4 <= pixel_in;
                    pool_addr       <= win_cnt;
                    map_idx         <= map_cnt;
                    pool_enable     <= 1'b1;
                    win_cnt         <= win_cnt + 1'b1;
                end
                if (at_col_end) begin
                    col <= '0;
                    if (at_row_end) begin
                        // End of map: the window-counter restart takes
                        // priority over the increment of the final window.
                        row        <= '0;
                        win_cnt    <= '0;
                        map_done   <= 1'b1;
                        frame_done <= at_map_last;
                        map_cnt    <= at_map_last ? '0 : map_cnt + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// ---------------------------------------------------------------------------
// tb_pool_window_gen
//   Bench for pool_window_gen with two instances: dut_a (IFM_SIZE=4,
//   IFM_DEPTH=3) and dut_b (IFM_SIZE=5, IFM_DEPTH=1). A reference model
//   stores the incoming image and pushes each expected window into a queue
//   when its closing pixel is driven; windows are popped when the DUT
//   strobes. Strobes and held outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_pool_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_clear, a_valid;
    logic [31:0] a_pixel;
    logic        a_pe, a_md, a_fd;
    logic [31:0] a_d1, a_d2, a_d3, a_d4;
    logic [1:0]  a_addr;
    logic [1:0]  a_map;

    logic        b_reset, b_clear, b_valid;
    logic [31:0] b_pixel;
    logic        b_pe, b_md, b_fd;
    logic [31:0] b_d1, b_d2, b_d3, b_d4;
    logic [1:0]  b_addr;
    logic [0:0]  b_map;

    pool_window_gen #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(3)) dut_a (
        .clk(clk), .reset(a_reset), .clear(a_clear),
        .pixel_valid(a_valid), .pixel_in(a_pixel),
        .pool_enable(a_pe),
        .pool_data_out_1(a_d1), .pool_data_out_2(a_d2),
        .pool_data_out_3(a_d3), .pool_data_out_4(a_d4),
        .pool_addr(a_addr), .map_idx(a_map),
        .map_done(a_md), .frame_done(a_fd)
    );

    pool_window_gen #(.DATA_WIDTH(32), .IFM_SIZE(5), .IFM_DEPTH(1)) dut_b (
        .clk(clk), .reset(b_reset), .clear(b_clear),
        .pixel_valid(b_valid), .pixel_in(b_pixel),
        .pool_enable(b_pe),
        .pool_data_out_1(b_d1), .pool_data_out_2(b_d2),
        .pool_data_out_3(b_d3), .pool_data_out_4(b_d4),
        .pool_addr(b_addr), .map_idx(b_map),
        .map_done(b_md), .frame_done(b_fd)
    );

    typedef struct packed {
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] w4;
        logic [7:0]  addr;
        logic [7:0]  mapn;
    } win_t;

    win_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int          m_row  [2];
    int          m_col  [2];
    int          m_map  [2];
    int          m_wcnt [2];
    logic [31:0] img    [2][5][5];
    logic [31:0] last_d [2][4];
    int          last_addr [2];
    int          last_map  [2];

    int win_seen, md_seen, fd_seen;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive instance s, advance the model, then compare outputs.
    task automatic step(input int s, input bit v, input bit clr, input bit rs, input logic [31:0] d);
        int   n, dp, r, c;
        bit   e_pe, e_md, e_fd;
        logic o_pe, o_md, o_fd;
        logic [31:0] o_d [4];
        int   o_addr, o_map;
        win_t w;
        n  = (s == 0) ? 4 : 5;
        dp = (s == 0) ? 3 : 1;
        @(negedge clk);
        a_valid = (s == 0) && v;  a_clear = (s == 0) && clr;
        a_reset = (s == 0) && rs; a_pixel = d;
        b_valid = (s == 1) && v;  b_clear = (s == 1) && clr;
        b_reset = (s == 1) && rs; b_pixel = d;
        e_pe = 1'b0; e_md = 1'b0; e_fd = 1'b0;
        if (rs || clr) begin
            m_row[s] = 0; m_col[s] = 0; m_map[s] = 0; m_wcnt[s] = 0;
            for (int i = 0; i < 4; i++) last_d[s][i] = '0;
            last_addr[s] = 0; last_map[s] = 0;
            q.delete();
        end else if (v) begin
            r = m_row[s]; c = m_col[s];
            img[s][r][c] = d;
            // Windows close on odd (row,col) up to index 3 for both sizes.
            if ((r % 2 == 1) && (c % 2 == 1) && r <= 3 && c <= 3) begin
                w.w1 = img[s][r-1][c-1]; w.w2 = img[s][r-1][c];
                w.w3 = img[s][r][c-1];   w.w4 = d;
                w.addr = 8'(m_wcnt[s]);  w.mapn = 8'(m_map[s]);
                q.push_back(w);
                m_wcnt[s]++;
                e_pe = 1'b1;
            end
            if (c == n - 1) begin
                m_col[s] = 0;
                if (r == n - 1) begin
                    m_row[s] = 0; m_wcnt[s] = 0;
                    e_md = 1'b1;
                    e_fd = (m_map[s] == dp - 1);
                    m_map[s] = (m_map[s] == dp - 1) ? 0 : m_map[s] + 1;
                end else begin
                    m_row[s] = r + 1;
                end
            end else begin
                m_col[s] = c + 1;
            end
        end
        @(posedge clk);
        #1;
        if (s == 0) begin
            o_pe = a_pe; o_md = a_md; o_fd = a_fd;
            o_d[0] = a_d1; o_d[1] = a_d2; o_d[2] = a_d3; o_d[3] = a_d4;
            o_addr = 32'(a_addr); o_map = 32'(a_map);
        end else begin
            o_pe = b_pe; o_md = b_md; o_fd = b_fd;
            o_d[0] = b_d1; o_d[1] = b_d2; o_d[2] = b_d3; o_d[3] = b_d4;
            o_addr = 32'(b_addr); o_map = 32'(b_map);
        end
        if (o_pe) begin
            win_seen++;
            if (q.size() == 0) begin
                check_val("unexpected_window", 64'(o_pe), 64'd0);
            end else begin
                w = q.pop_front();
                last_d[s][0] = w.w1; last_d[s][1] = w.w2;
                last_d[s][2] = w.w3; last_d[s][3] = w.w4;
                last_addr[s] = 32'(w.addr); last_map[s] = 32'(w.mapn);
            end
        end
        if (o_md) md_seen++;
        if (o_fd) fd_seen++;
        check_val("pool_enable", 64'(o_pe), 64'(e_pe));
        check_val("data_out_1", 64'(o_d[0]), 64'(last_d[s][0]));
        check_val("data_out_2", 64'(o_d[1]), 64'(last_d[s][1]));
        check_val("data_out_3", 64'(o_d[2]), 64'(last_d[s][2]));
        check_val("data_out_4", 64'(o_d[3]), 64'(last_d[s][3]));
        check_val("pool_addr", 64'(o_addr), 64'(last_addr[s]));
        check_val("map_idx", 64'(o_map), 64'(last_map[s]));
        check_val("map_done", 64'(o_md), 64'(e_md));
        check_val("frame_done", 64'(o_fd), 64'(e_fd));
    endtask

    task automatic clear_counts();
        win_seen = 0; md_seen = 0; fd_seen = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit v;
        for (int s = 0; s < 2; s++) begin
            m_row[s] = 0; m_col[s] = 0; m_map[s] = 0; m_wcnt[s] = 0;
            last_addr[s] = 0; last_map[s] = 0;
            for (int i = 0; i < 4; i++) last_d[s][i] = '0;
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) img[s][i][j] = '0;
        end
        clear_counts();
        a_reset = 1'b1; b_reset = 1'b1;
        a_clear = 1'b0; b_clear = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_pixel = '0;   b_pixel = '0;
        #23;

        // Reset state of both instances
        step(0, 1'b0, 1'b0, 1'b1, 32'd0);
        step(1, 1'b0, 1'b0, 1'b1, 32'd0);
        step(0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Odd size: 5x5, last row/column never form windows
        clear_counts();
        for (int i = 0; i < 25; i++) step(1, 1'b1, 1'b0, 1'b0, 32'(i));
        step(1, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("b_windows", 64'(win_seen), 64'd4);
        check_val("b_map_done_cnt", 64'(md_seen), 64'd1);
        check_val("b_frame_done_cnt", 64'(fd_seen), 64'd1);
        check_val("b_hold_d1", 64'(b_d1), 64'd12);
        check_val("b_hold_d4", 64'(b_d4), 64'd18);
        check_val("b_hold_addr", 64'(b_addr), 64'd3);

        // 3 maps of 4x4 back-to-back
        clear_counts();
        for (int i = 0; i < 48; i++) step(0, 1'b1, 1'b0, 1'b0, 32'(i));
        step(0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("a_windows", 64'(win_seen), 64'd12);
        check_val("a_map_done_cnt", 64'(md_seen), 64'd3);
        check_val("a_frame_done_cnt", 64'(fd_seen), 64'd1);
        check_val("a_hold_d1", 64'(a_d1), 64'd42);
        check_val("a_hold_d2", 64'(a_d2), 64'd43);
        check_val("a_hold_d3", 64'(a_d3), 64'd46);
        check_val("a_hold_map", 64'(a_map), 64'd2);

        // Same frame with random stalls
        clear_counts();
        k = 0;
        while (k < 48) begin
            v = 1'($urandom_range(0, 1));
            step(0, v, 1'b0, 1'b0, v ? 32'(k) : $urandom);
            if (v) k++;
        end
        step(0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("gap_windows", 64'(win_seen), 64'd12);
        check_val("gap_frame_done_cnt", 64'(fd_seen), 64'd1);

        // Reset mid-frame with pixel_valid held high
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 1'b0, 32'(50 + i));
        step(0, 1'b1, 1'b0, 1'b1, 32'd77);
        step(0, 1'b1, 1'b0, 1'b1, 32'd78);
        clear_counts();
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b0, 32'(100 + i));
        step(0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("rst_windows", 64'(win_seen), 64'd4);
        check_val("rst_map_done_cnt", 64'(md_seen), 64'd1);
        check_val("rst_hold_d1", 64'(a_d1), 64'd110);
        check_val("rst_hold_d4", 64'(a_d4), 64'd115);
        check_val("rst_hold_map", 64'(a_map), 64'd0);

        // Clear drops the pixel presented with it
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0, 32'(200 + i));
        step(0, 1'b1, 1'b1, 1'b0, 32'd999);
        clear_counts();
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b0, 32'(300 + i));
        step(0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("clr_windows", 64'(win_seen), 64'd4);
        check_val("clr_hold_d1", 64'(a_d1), 64'd310);
        check_val("clr_hold_d2", 64'(a_d2), 64'd311);
        check_val("clr_hold_addr", 64'(a_addr), 64'd3);

        check_val("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Streaming 2x2 / stride-2 window extractor that feeds the average-pooling stage.
- Accepts one IFM pixel per valid cycle in raster order (row-major), map by map, for IFM_DEPTH maps.
- Buffers one row plus one pixel in a shift register.
- On every pixel that completes a 2x2 window, presents the four window pixels with a one-cycle pool_enable strobe and the output address of that pooled pixel.

Parameters:
- DATA_WIDTH, 32, pixel word width (IEEE-754 single; treated as opaque bits).
- IFM_SIZE, 14, IFM height = width in pixels (>= 2).
- IFM_DEPTH, 3, number of maps per frame.
- IFM_SIZE_NEXT, (IFM_SIZE-2)/2+1, pooled map height = width (integer floor).
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), pooled-address width.
- BUF_SIZE, IFM_SIZE+1, shift-register depth in words.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous restart: counters and outputs to reset state; buffer contents may remain.
- pixel_valid  in  1  pixel_in is accepted on this edge.
- pixel_in  in  DATA_WIDTH  IFM pixel.
- pool_enable  out  1  one-cycle strobe: window outputs valid.
- pool_data_out_1  out  DATA_WIDTH  window pixel (r-1,c-1).
- pool_data_out_2  out  DATA_WIDTH  window pixel (r-1,c).
- pool_data_out_3  out  DATA_WIDTH  window pixel (r,c-1).
- pool_data_out_4  out  DATA_WIDTH  window pixel (r,c).
- pool_addr  out  ADDRESS_SIZE_NEXT_IFM  pooled-map address of this window (row-major).
- map_idx  out  $clog2(IFM_DEPTH) (min 1)  map the window belongs to.
- map_done  out  1  one-cycle pulse with the last accepted pixel of a map.
- frame_done  out  1  one-cycle pulse with the last accepted pixel of the last map.

Behaviour:
- Reset (async) or clear (sync): all outputs 0; col, row, map, and address counters 0. clear overrides pixel_valid; a pixel presented with clear is dropped.
- pixel_valid low: everything holds, including the shift register and counters. Strobes deassert the cycle after they fire.
- Accept (pixel_valid=1, clear=0) at counter position (row,col):
  - Shift register shifts; sr[0] <= pixel_in; sr[k] <= sr[k-1].
  - Before the shift, sr[0] = (row,col-1), sr[IFM_SIZE-1] = (row-1,col), sr[IFM_SIZE] = (row-1,col-1).
- Window condition: row[0]=1, col[0]=1, row < 2*IFM_SIZE_NEXT, col < 2*IFM_SIZE_NEXT. For odd IFM_SIZE, the last row and column never form windows.
- On an accepted pixel meeting the window condition, these registers load on the same edge (latency 1 cycle from pixel to strobe):
  - out_1 <= sr[IFM_SIZE], out_2 <= sr[IFM_SIZE-1], out_3 <= sr[0], out_4 <= pixel_in.
  - pool_addr <= window counter; map_idx <= map.
  - pool_enable <= 1.
  - Window counter increments.
- Otherwise pool_enable <= 0 and the data, address, and map_idx outputs hold their last values.
- Counters:
  - col wraps IFM_SIZE-1 -> 0 and increments row.
  - row wraps IFM_SIZE-1 -> 0 at end of map; the map counter increments and the window counter resets to 0.
  - map wraps IFM_DEPTH-1 -> 0 at end of frame.
- map_done <= 1 on the edge accepting (IFM_SIZE-1, IFM_SIZE-1). frame_done is additionally 1 if map = IFM_DEPTH-1.
- Simultaneous events: the last window of a map (even IFM_SIZE) fires in the same cycle as map_done/frame_done, with the old pool_addr and map_idx.
- Back-to-back frames need no gap. Buffer contents spanning a map boundary are never used in a window.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of map 0.

Test Plan:
- IFM_SIZE=4, IFM_DEPTH=1, pixels 0..15 continuous -> exactly four pool_enable pulses, each one cycle after accepting pixels 5, 7, 13, 15:
  - (0,1,4,5) addr 0
  - (2,3,6,7) addr 1
  - (8,9,12,13) addr 2
  - (10,11,14,15) addr 3
  - map_done and frame_done pulse together with the last window.
- IFM_SIZE=5, pixels 0..24 -> windows (0,1,5,6), (2,3,7,8), (10,11,15,16), (12,13,17,18) at addr 0..3; no strobe for row/col 4; map_done after pixel 24.
- IFM_SIZE=4, pseudo-random pixel_valid gaps (~50%), same data -> identical window values and addresses; no strobe on stalled cycles.
- IFM_SIZE=4, IFM_DEPTH=3, 48 pixels back-to-back:
  - map_idx is 0/1/2 for each group of four windows; pool_addr restarts at 0 per map.
  - map_done fires 3 times; frame_done fires once, after pixel 47.
- Assert reset after 9 pixels, then send 16 fresh pixels 100..115 -> first window is (100,101,104,105) addr 0; no strobe during reset.
- Pulse clear with pixel_valid=1 -> that pixel is dropped; the next accepted pixel is (0,0) map 0.
